// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_queue_pkg;
  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0]    PC_STEP   = 32'd4;
  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_storage.sv
// DEPTH x {pc, instr} register file: one synchronous write port, one asynchronous read port.
module fetch_queue_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic            Clock,
  input  logic            we,
  input  logic [PW-1:0]   waddr,
  input  fq_entry_t       wdata,
  input  logic [PW-1:0]   raddr,
  output fq_entry_t       rdata
);
  // Contents are meaningless until written, so the array carries no reset.
  fq_entry_t [DEPTH-1:0] mem;

  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Prefetch FIFO between instruction fetch and decode with flush and full back-pressure.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   FetchValid,
  input  logic [PC_WIDTH-1:0]    FetchPC,
  input  logic [INSTR_WIDTH-1:0] FetchInstr,
  output logic                   FetchReady,
  input  logic                   Flush,
  output logic                   DecValid,
  output logic [PC_WIDTH-1:0]    DecPC,
  output logic [PC_WIDTH-1:0]    DecPCPlus4,
  output logic [INSTR_WIDTH-1:0] DecInstr,
  input  logic                   DecReady,
  output logic [CW-1:0]          Count
);
  logic [PW-1:0] wptr, rptr;
  logic          push, pop;
  fq_entry_t     wdata, head;

  // Readiness depends only on state, never on DecReady, so a full queue
  // refuses a push even while decode is popping.
  assign FetchReady = Reset & (Count < CW'(DEPTH));
  assign DecValid   = (Count != '0);
  assign push       = FetchValid & FetchReady & ~Flush;
  assign pop        = DecValid & DecReady & ~Flush;
  assign wdata      = '{pc: FetchPC, instr: FetchInstr};

  fetch_queue_storage #(.DEPTH(DEPTH)) u_storage (
    .Clock (Clock),
    .we    (push),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (head)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wptr  <= '0;
      rptr  <= '0;
      Count <= '0;
    end else if (Flush) begin
      wptr  <= '0;
      rptr  <= '0;
      Count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Empty queue presents a NOP bubble with zeroed addresses.
  assign DecPC      = DecValid ? head.pc           : '0;
  assign DecPCPlus4 = DecValid ? head.pc + PC_STEP : '0;
  assign DecInstr   = DecValid ? head.instr        : INSTR_NOP;
endmodule
